// File: rtl/accum_pkg.sv
// Shared types and default widths for the accumulator stage.
package accum_pkg;
   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_DRAIN} state_e;

   localparam int LANES_DEF      = 4;
   localparam int PSUM_W_DEF     = 24;
   localparam int ACC_GUARD      = 6;
   localparam int ACC_W_DEF      = PSUM_W_DEF + ACC_GUARD;
   localparam int BIAS_W_DEF     = 16;
   localparam int OUT_W_DEF      = 16;
   localparam int FRAC_SHIFT_DEF = 8;

   function automatic int lane_w(input int lanes);
      return (lanes > 1) ? $clog2(lanes) : 1;
   endfunction
endpackage

// File: rtl/accum_if.sv
// Bus between the top controller / PE array / output buffer and accum_controller.
interface accum_if import accum_pkg::*; #(
   parameter int LANES  = LANES_DEF,
   parameter int PSUM_W = PSUM_W_DEF,
   parameter int BIAS_W = BIAS_W_DEF,
   parameter int OUT_W  = OUT_W_DEF
) ();
   localparam int LW = lane_w(LANES);

   logic                      accum_activate;
   logic                      ker_change;
   logic                      en_bias_mem;
   logic [BIAS_W-1:0]         bias_data;
   logic                      psum_valid;
   logic [LANES*PSUM_W-1:0]   psum_data;
   logic                      go_next_stage;
   logic                      out_valid;
   logic                      out_ready;
   logic [OUT_W-1:0]          out_data;
   logic [LW-1:0]             out_lane;
   logic                      drain_busy;
   logic                      ovr_err;

   modport master (
      output accum_activate, ker_change, en_bias_mem, bias_data, psum_valid, psum_data, out_ready,
      input  go_next_stage, out_valid, out_data, out_lane, drain_busy, ovr_err
   );
   modport slave (
      input  accum_activate, ker_change, en_bias_mem, bias_data, psum_valid, psum_data, out_ready,
      output go_next_stage, out_valid, out_data, out_lane, drain_busy, ovr_err
   );
endinterface

// File: rtl/out_quantizer.sv
// Drain-side quantizer: arithmetic shift, saturate to OUT_W, optional ReLU.
// Define ACCUM_RELU_EN to clamp negative results to zero.
module out_quantizer #(
   parameter int ACC_W      = 30,
   parameter int OUT_W      = 16,
   parameter int FRAC_SHIFT = 8
) (
   input  logic signed [ACC_W-1:0] acc_i,
   output logic        [OUT_W-1:0] q_o
);
   localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

   logic signed [ACC_W-1:0] shifted;
   logic        [OUT_W-1:0] sat;

   always_comb begin
      shifted = acc_i >>> FRAC_SHIFT;
      if (shifted > SAT_MAX)      sat = SAT_MAX[OUT_W-1:0];
      else if (shifted < SAT_MIN) sat = SAT_MIN[OUT_W-1:0];
      else                        sat = shifted[OUT_W-1:0];
`ifdef ACCUM_RELU_EN
      q_o = sat[OUT_W-1] ? '0 : sat;
`else
      q_o = sat;
`endif
   end
endmodule

// File: rtl/accum_controller.sv
// Per-stage lane accumulation seeded with bias, then serial quantized drain.
// ReLU at drain is enabled by defining ACCUM_RELU_EN (see out_quantizer).
module accum_controller import accum_pkg::*; #(
   parameter int LANES      = LANES_DEF,
   parameter int PSUM_W     = PSUM_W_DEF,
   parameter int ACC_W      = ACC_W_DEF,
   parameter int BIAS_W     = BIAS_W_DEF,
   parameter int OUT_W      = OUT_W_DEF,
   parameter int FRAC_SHIFT = FRAC_SHIFT_DEF
) (
   input logic   clk,
   input logic   rst_n,
   accum_if.slave bus
);
   localparam int            LW        = lane_w(LANES);
   localparam logic [LW-1:0] LAST_LANE = LW'(LANES-1);

   state_e                       state_q, state_d;
   logic [LANES-1:0][ACC_W-1:0]  acc_q, acc_d;
   logic [BIAS_W-1:0]            bias_q, bias_d;
   logic [LW-1:0]                lane_q, lane_d;
   logic bias_rd_q, ker_prev_q;
   logic first_q, first_d, go_q, go_d, out_valid_q, out_valid_d;
   logic busy_q, busy_d, ovr_q, ovr_d;
   logic ker_edge;
   logic signed [ACC_W-1:0] base, psum_ext, lane_acc;
   logic [OUT_W-1:0]        q_data;

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      bias_d      = bias_rd_q ? bus.bias_data : bias_q;
      lane_d      = lane_q;
      first_d     = first_q;
      go_d        = 1'b0;
      out_valid_d = out_valid_q;
      busy_d      = busy_q;
      ovr_d       = ovr_q;
      base        = '0;
      psum_ext    = '0;
      ker_edge    = bus.ker_change & ~ker_prev_q;
      case (state_q)
         S_IDLE:
            if (ker_edge) begin
               state_d     = S_DRAIN;
               lane_d      = '0;
               out_valid_d = 1'b1;
               busy_d      = 1'b1;
            end else if (bus.accum_activate) begin
               state_d = S_WAIT;
            end
         S_WAIT:
            if (bus.psum_valid) begin
               state_d = S_ACK;
               go_d    = 1'b1;
               first_d = 1'b0;
               for (int i = 0; i < LANES; i++) begin
                  base     = first_q ? ACC_W'(signed'(bias_q)) : signed'(acc_q[i]);
                  psum_ext = ACC_W'(signed'(bus.psum_data[i*PSUM_W +: PSUM_W]));
                  acc_d[i] = base + psum_ext;
               end
            end else if (!bus.accum_activate) begin
               state_d = S_IDLE;
            end
         S_ACK: state_d = S_IDLE;
         S_DRAIN: begin
            // A new kernel boundary mid-drain is flagged, never restarts the drain
            if (ker_edge) ovr_d = 1'b1;
            if (out_valid_q && bus.out_ready) begin
               if (lane_q == LAST_LANE) begin
                  state_d     = S_IDLE;
                  acc_d       = '0;
                  first_d     = 1'b1;
                  out_valid_d = 1'b0;
                  busy_d      = 1'b0;
                  lane_d      = '0;
               end else begin
                  lane_d = lane_q + 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         acc_q       <= '0;
         bias_q      <= '0;
         lane_q      <= '0;
         bias_rd_q   <= 1'b0;
         ker_prev_q  <= 1'b0;
         first_q     <= 1'b1;
         go_q        <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         ovr_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         bias_q      <= bias_d;
         lane_q      <= lane_d;
         bias_rd_q   <= bus.en_bias_mem;
         ker_prev_q  <= bus.ker_change;
         first_q     <= first_d;
         go_q        <= go_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
         ovr_q       <= ovr_d;
      end
   end

   assign lane_acc = acc_q[lane_q];

   out_quantizer #(.ACC_W(ACC_W), .OUT_W(OUT_W), .FRAC_SHIFT(FRAC_SHIFT)) u_quant (
      .acc_i (lane_acc),
      .q_o   (q_data)
   );

   assign bus.out_data      = q_data;
   assign bus.out_lane      = lane_q;
   assign bus.out_valid     = out_valid_q;
   assign bus.go_next_stage = go_q;
   assign bus.drain_busy    = busy_q;
   assign bus.ovr_err       = ovr_q;
endmodule

// File: tb/tb_accum_controller.sv
// Scoreboard bench: a lane-array model predicts drained words, a negedge monitor checks them.
module tb_accum_controller;
   import accum_pkg::*;
   localparam int LANES = 4, PSUM_W = 24, ACC_W = 30, BIAS_W = 16, OUT_W = 16, FS = 8;
   localparam int LW = lane_w(LANES);

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   accum_if #(.LANES(LANES), .PSUM_W(PSUM_W), .BIAS_W(BIAS_W), .OUT_W(OUT_W)) bus ();

   accum_controller #(.LANES(LANES), .PSUM_W(PSUM_W), .ACC_W(ACC_W), .BIAS_W(BIAS_W),
                      .OUT_W(OUT_W), .FRAC_SHIFT(FS)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {logic [OUT_W-1:0] data; logic [LW-1:0] lane;} exp_t;
   exp_t   exp_q[$];
   bit     rdy_q[$];
   bit     rdy_rand = 1'b0;
   int     n_vec = 0, n_err = 0, drain_cyc = 0;
   longint acc_m[LANES];
   longint ps[LANES];
   longint bias_m = 0;
   bit     first_m = 1'b1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic logic [OUT_W-1:0] qref(input longint a);
      longint s, hi, lo;
      hi = (longint'(1) << (OUT_W-1)) - 1;
      lo = -hi - 1;
      s  = a >>> FS;
      if (s > hi) s = hi;
      else if (s < lo) s = lo;
`ifdef ACCUM_RELU_EN
      if (s < 0) s = 0;
`endif
      return OUT_W'(s);
   endfunction

   function automatic longint rnd_psum();
      logic signed [PSUM_W-1:0] r;
      r = PSUM_W'($urandom);
      return longint'(r);
   endfunction

   function automatic longint rnd_bias();
      logic signed [BIAS_W-1:0] r;
      r = BIAS_W'($urandom);
      return longint'(r);
   endfunction

   function automatic bit next_rdy();
      if (rdy_q.size() != 0) return rdy_q.pop_front();
      return rdy_rand ? bit'($urandom_range(0, 1)) : 1'b1;
   endfunction

   task automatic model_clear();
      foreach (acc_m[i]) acc_m[i] = 0;
      first_m = 1'b1;
   endtask

   // Monitor: every presented word must match the head of the queue; pop on accept.
   always @(negedge clk) begin
      if (rst_n && bus.out_valid) begin
         n_vec++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL out_unexpected: lane %0d data %0d with nothing expected", bus.out_lane, bus.out_data);
         end else begin
            if (bus.out_data !== exp_q[0].data || bus.out_lane !== exp_q[0].lane) begin
               n_err++;
               $display("FAIL out_word: got lane %0d data %0d expected lane %0d data %0d",
                        bus.out_lane, bus.out_data, exp_q[0].lane, exp_q[0].data);
            end
            if (bus.out_ready) void'(exp_q.pop_front());
         end
      end
   end

   task automatic load_bias(input longint b);
      @(posedge clk); #1 bus.en_bias_mem = 1'b1; bus.bias_data = BIAS_W'($urandom);
      @(posedge clk); #1 bus.en_bias_mem = 1'b0; bus.bias_data = BIAS_W'(b);
      @(posedge clk); #1 bus.bias_data = BIAS_W'($urandom);
      bias_m = b;
   endtask

   task automatic do_stage();
      @(posedge clk); #1 bus.accum_activate = 1'b1;
      @(posedge clk); #1 bus.psum_valid = 1'b1;
      for (int i = 0; i < LANES; i++) bus.psum_data[i*PSUM_W +: PSUM_W] = PSUM_W'(ps[i]);
      @(posedge clk); #1 bus.psum_valid = 1'b0;
      chk("go_high", bus.go_next_stage, 1);
      for (int i = 0; i < LANES; i++) acc_m[i] = (first_m ? bias_m : acc_m[i]) + ps[i];
      first_m = 1'b0;
      @(posedge clk); #1 bus.accum_activate = 1'b0;
      chk("go_one_cycle", bus.go_next_stage, 0);
   endtask

   task automatic noise();
      @(posedge clk); #1 bus.psum_valid = 1'b1; bus.psum_data = {LANES{PSUM_W'($urandom)}};
      @(posedge clk); #1 bus.psum_valid = 1'b0; bus.accum_activate = 1'b1;
      @(posedge clk); #1 bus.accum_activate = 1'b0; bus.ker_change = 1'b1;
      @(posedge clk); #1 chk("wait_ker_ignored", bus.drain_busy, 0);
      chk("wait_no_go", bus.go_next_stage, 0);
      @(posedge clk); #1 bus.ker_change = 1'b0;
      chk("ker_held_no_edge", bus.drain_busy, 0);
   endtask

   task automatic do_drain(input int hold, input int reedge);
      bit done = 1'b0;
      for (int i = 0; i < LANES; i++) exp_q.push_back('{data: qref(acc_m[i]), lane: LW'(i)});
      model_clear();
      @(posedge clk); #1 bus.ker_change = 1'b1;
      @(posedge clk); #1 chk("drain_valid", bus.out_valid, 1);
      chk("drain_busy", bus.drain_busy, 1);
      for (int k = 0; k < 400 && !done; k++) begin
         bus.out_ready = next_rdy();
         if (k == hold)   bus.ker_change = 1'b0;
         if (k == reedge) bus.ker_change = 1'b1;
         @(posedge clk); #1;
         if (!bus.drain_busy) begin done = 1'b1; drain_cyc = k + 1; end
      end
      chk("drain_done_in_budget", done, 1);
      bus.out_ready = 1'b0;
      @(posedge clk); #1 chk("single_drain", bus.drain_busy, 0);
      bus.ker_change = 1'b0;
      chk("drain_all_words", exp_q.size(), 0);
      exp_q.delete();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: got running expected finished");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
      $fatal(1);
   end

   initial begin
      bit seen;
      bus.accum_activate = 1'b0; bus.ker_change = 1'b0; bus.en_bias_mem = 1'b0;
      bus.bias_data = '0; bus.psum_valid = 1'b0; bus.psum_data = '0; bus.out_ready = 1'b0;
      model_clear();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_go", bus.go_next_stage, 0);
      chk("rst_valid", bus.out_valid, 0);
      chk("rst_data", bus.out_data, 0);
      chk("rst_lane", bus.out_lane, 0);
      chk("rst_busy", bus.drain_busy, 0);
      chk("rst_ovr", bus.ovr_err, 0);
      rst_n = 1'b1;

      // bias 10, psum [100,-5,0,7], scaled by 2^FS so the drain yields [110,5,10,17]
      load_bias(10 << FS);
      ps = '{100 << FS, -(5 << FS), 0, 7 << FS};
      do_stage();
      do_drain(1, -1);
      chk("drain_len", drain_cyc, LANES);

      // Three stages of 1000 -> 3000 >>> 8 = 11
      load_bias(0);
      ps = '{1000, 1000, 1000, 1000};
      repeat (3) do_stage();
      do_drain(0, -1);

      // Saturation, both signs
      ps = '{(1 << 23) - 1, (1 << 23) - 1, (1 << 23) - 1, (1 << 23) - 1};
      repeat (40) do_stage();
      do_drain(0, -1);
      ps = '{-(1 << 23), -(1 << 23), -(1 << 23), -(1 << 23)};
      repeat (40) do_stage();
      do_drain(0, -1);

      // Stall pattern 1,0,0,1
      load_bias(rnd_bias());
      foreach (ps[i]) ps[i] = rnd_psum();
      do_stage();
      rdy_q = '{1, 0, 0, 1};
      do_drain(0, -1);

      // Randomized stages, bias reuse, ignored inputs and random back-pressure
      for (int it = 0; it < 20; it++) begin
         if ($urandom_range(0, 3) == 0) noise();
         if ($urandom_range(0, 1) == 1) load_bias(rnd_bias());
         for (int s = 0; s < int'($urandom_range(1, 4)); s++) begin
            foreach (ps[i]) ps[i] = rnd_psum();
            do_stage();
         end
         rdy_rand = 1'b1;
         do_drain(int'($urandom_range(0, 6)), -1);
         rdy_rand = 1'b0;
      end

      // ker_change held 5 cycles, then a second edge mid-drain
      chk("ovr_clear", bus.ovr_err, 0);
      foreach (ps[i]) ps[i] = rnd_psum();
      do_stage();
      rdy_q = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      do_drain(5, 7);
      chk("ovr_set", bus.ovr_err, 1);

      // Reset at lane 2 of a drain
      load_bias(rnd_bias());
      foreach (ps[i]) ps[i] = rnd_psum();
      do_stage();
      for (int i = 0; i < LANES; i++) exp_q.push_back('{data: qref(acc_m[i]), lane: LW'(i)});
      @(posedge clk); #1 bus.ker_change = 1'b1; bus.out_ready = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         @(posedge clk); #1;
         if (bus.out_valid && bus.out_lane == LW'(2)) seen = 1'b1;
      end
      chk("reached_lane2", seen, 1);
      rst_n = 1'b0; bus.out_ready = 1'b0; bus.ker_change = 1'b0;
      exp_q.delete();
      model_clear();
      bias_m = 0;
      #1;
      chk("mid_rst_valid", bus.out_valid, 0);
      chk("mid_rst_busy", bus.drain_busy, 0);
      chk("mid_rst_lane", bus.out_lane, 0);
      chk("mid_rst_data", bus.out_data, 0);
      chk("mid_rst_ovr", bus.ovr_err, 0);
      @(posedge clk); #1 rst_n = 1'b1;
      load_bias(rnd_bias());
      foreach (ps[i]) ps[i] = rnd_psum();
      do_stage();
      do_drain(0, -1);

      repeat (3) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
